// File: rtl/fetch_sequencer_pkg.sv
// Shared types and widths for the instruction fetch path.
package fetch_pkg;
   localparam int WORD_BYTES = 4;
   localparam int ADDR_W     = 16;
   localparam int INST_W     = 16;

   typedef enum logic [1:0] {FETCH, HOLD, FAULT} fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_sequencer_fifo.sv
// Prefetch FIFO of {pc, inst}; flush wins over push/pop, push allowed when full if popping.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem_q [DEPTH];
   logic [AW:0]    wr_q, rd_q;
   logic           do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   // Head comes straight from register storage, so it reads 0 out of reset.
   assign head_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
            wr_q                <= wr_q + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: PC, fault FSM and prefetch FIFO feeding decode.
// Optional FETCH_BYPASS_EN: zero-latency delivery when the FIFO is empty.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                MEM_SIZE = 1024,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              fetch_fault,
   output logic [ADDR_W-1:0] fault_pc
);
   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q, fault_pc_q;
   logic              full, empty, oob, fetch, push, pop, bypass;
   fetch_entry_t      head, entry;

   // 17-bit sum so a PC near 16'hFFFF cannot wrap past the check.
   assign oob         = ({1'b0, pc_q} + 17'd3) >= 17'(MEM_SIZE);
   assign fetch_fault = (state_q == FAULT);
   assign fault_pc    = fault_pc_q;
   assign imem_addr   = pc_q;
   assign pop         = inst_ready && !empty;
   assign fetch       = run && !fetch_fault && !redirect_valid && !oob && (!full || pop);

`ifdef FETCH_BYPASS_EN
   assign bypass = fetch && empty;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed instruction consumed this cycle never enters the FIFO.
   assign push       = fetch && !(bypass && inst_ready);
   assign entry.pc   = pc_q;
   assign entry.inst = imem_data;
   assign inst_valid = !empty || bypass;
   assign inst       = bypass ? imem_data : head.inst;
   assign inst_pc    = bypass ? pc_q : head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .data_i  (entry),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         fault_pc_q <= '0;
      end else if (redirect_valid) begin
         if (redirect_pc[1:0] != 2'b00) begin
            state_q    <= FAULT;
            fault_pc_q <= redirect_pc;
         end else begin
            state_q <= run ? FETCH : HOLD;
            pc_q    <= redirect_pc;
         end
      end else if (state_q != FAULT) begin
         if (run && oob) begin
            state_q    <= FAULT;
            fault_pc_q <= pc_q;
         end else begin
            state_q <= run ? FETCH : HOLD;
            if (fetch) pc_q <= pc_q + ADDR_W'(WORD_BYTES);
         end
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised bench for fetch_sequencer against a queue-based behavioural model.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam int MEM_SIZE = 1024;
   localparam int DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] imem_addr, imem_data, inst, inst_pc, fault_pc;
   logic        inst_valid, fetch_fault;
   logic [15:0] rom [MEM_SIZE/4];

   always #5 clk = ~clk;

   assign imem_data = (imem_addr < 16'(MEM_SIZE)) ? rom[imem_addr[9:2]] : 16'hDEAD;

   fetch_sequencer #(.MEM_SIZE(MEM_SIZE), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .fetch_fault(fetch_fault),
      .fault_pc(fault_pc)
   );

   // Model: program counter, fault flag and an ordered list of pending fetches.
   int          m_pc;
   logic        m_fault;
   logic [15:0] m_fpc;
   int          q_pc[$];
   logic [15:0] q_in[$];
   int          pass_cnt = 0, total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic m_fire(input logic r, input logic rv, input logic rdy);
      logic in_range;
      in_range = (m_pc + 3) < MEM_SIZE;
      return r && !rv && !m_fault && in_range && (q_pc.size() < DEPTH || rdy);
   endfunction

   task automatic model_reset();
      m_pc = 0; m_fault = 1'b0; m_fpc = '0;
      q_pc.delete(); q_in.delete();
   endtask

   // One clock: drive, compare against the model, then advance the model.
   task automatic cyc(input logic r, input logic rv, input logic [15:0] rpc, input logic rdy);
      logic fire, byp, pop, oob;
      @(negedge clk);
      run = r; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
      #1;
      fire = m_fire(r, rv, rdy);
      byp  = BYP && fire && (q_pc.size() == 0);
      chk("imem_addr", imem_addr, m_pc[15:0]);
      chk("fetch_fault", fetch_fault, m_fault);
      chk("fault_pc", fault_pc, m_fpc);
      chk("inst_valid", inst_valid, (q_pc.size() > 0) || byp);
      if (q_pc.size() > 0) begin
         chk("inst_pc", inst_pc, q_pc[0]);
         chk("inst", inst, q_in[0]);
      end else if (byp) begin
         chk("byp_inst_pc", inst_pc, m_pc[15:0]);
         chk("byp_inst", inst, rom[m_pc/4]);
      end
      oob = (m_pc + 3) >= MEM_SIZE;
      pop = rdy && (q_pc.size() > 0);
      if (rv) begin
         q_pc.delete(); q_in.delete();
         if (rpc[1:0] != 2'b00) begin
            m_fault = 1'b1; m_fpc = rpc;
         end else begin
            m_pc = int'(rpc); m_fault = 1'b0;
         end
      end else begin
         if (pop) begin
            void'(q_pc.pop_front()); void'(q_in.pop_front());
         end
         if (fire && !(byp && rdy)) begin
            q_pc.push_back(m_pc); q_in.push_back(rom[m_pc/4]);
         end
         if (fire) m_pc += 4;
         else if (r && !m_fault && oob) begin
            m_fault = 1'b1; m_fpc = m_pc[15:0];
         end
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      #1;
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_inst_pc", inst_pc, 16'h0000);
      chk("rst_fetch_fault", fetch_fault, 1'b0);
      chk("rst_fault_pc", fault_pc, 16'h0000);
      chk("rst_imem_addr", imem_addr, 16'h0000);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < MEM_SIZE/4; i++) rom[i] = 16'($urandom);
      model_reset();
      do_reset();

      // Streaming with decode always ready.
      cyc(1, 0, 0, 1); #2;
      chk("s1_valid", inst_valid, 1'b1);
`ifndef FETCH_BYPASS_EN
      chk("s1_pc0", inst_pc, 16'h0000);
`endif
      repeat (3) cyc(1, 0, 0, 1); #2;
`ifndef FETCH_BYPASS_EN
      chk("s1_pc12", inst_pc, 16'h000C);
`endif

      // Backpressure fills the FIFO, then drains.
      do_reset();
      repeat (10) cyc(1, 0, 0, 0); #2;
      chk("s2_stall_addr", imem_addr, 16'h0010);
      chk("s2_head_pc", inst_pc, 16'h0000);
      repeat (8) cyc(1, 0, 0, 1);

      // Redirect over a partly full FIFO.
      do_reset();
      repeat (3) cyc(1, 0, 0, 0);
      cyc(1, 1, 16'h0040, 1); #2;
      chk("s3_flush_valid", inst_valid, 1'b0);
      cyc(1, 0, 0, 1); #2;
`ifndef FETCH_BYPASS_EN
      chk("s3_target_pc", inst_pc, 16'h0040);
`endif
      repeat (3) cyc(1, 0, 0, 1);

      // Last word of ROM, then out of bounds.
      cyc(1, 1, 16'h03FC, 1);
      repeat (4) cyc(1, 0, 0, 1); #2;
      chk("s4_fault", fetch_fault, 1'b1);
      chk("s4_fault_pc", fault_pc, 16'h0400);
      chk("s4_addr_frozen", imem_addr, 16'h0400);
      cyc(1, 1, 16'h0008, 1);
      repeat (3) cyc(1, 0, 0, 1);

      // Misaligned redirect.
      cyc(1, 1, 16'h0012, 1); #2;
      chk("s5_fault", fetch_fault, 1'b1);
      chk("s5_fault_pc", fault_pc, 16'h0012);
      chk("s5_pc_kept", imem_addr, 16'h0014);
      chk("s5_empty", inst_valid, 1'b0);

      // Asynchronous reset with a full FIFO.
      cyc(1, 1, 16'h0000, 0);
      repeat (6) cyc(1, 0, 0, 0);
      do_reset();
      repeat (3) cyc(1, 0, 0, 1); #2;
      chk("s6_restart_addr", imem_addr, 16'h000C);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         logic r, rv, rdy;
         logic [15:0] t;
         r   = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 3))
            0:       t = 16'($urandom_range(0, 255)) << 2;
            1:       t = 16'h03F0 + (16'($urandom_range(0, 3)) << 2);
            2:       t = 16'($urandom_range(0, 1023));
            default: t = 16'($urandom_range(0, 15)) << 2;
         endcase
         cyc(r, rv, t, rdy);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
